// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects and load-use stall control with MEM/WB destination shadow
module fwd_hazard_unit #(
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] ex_rs,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] ex_dst,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          flush,
  output logic [1:0]    src1,
  output logic [1:0]    src2,
  output logic          stall,
  output logic          bubble,
  output logic [CW-1:0] stall_cnt
);
  logic [RW-1:0] r_mem_dst, r_wb_dst;
  logic          r_mem_rw, r_mem_ld, r_wb_rw;
  logic [CW-1:0] r_cnt;
  logic          w_mem_ok, w_wb_ok;
  // A load sitting in MEM has no data yet, so it is never a forward source.
  assign w_mem_ok  = r_mem_rw & ~r_mem_ld & (r_mem_dst != '0);
  assign w_wb_ok   = r_wb_rw & (r_wb_dst != '0);
  assign src1      = (w_mem_ok && r_mem_dst == ex_rs) ? 2'b01 :
                     (w_wb_ok && r_wb_dst == ex_rs)   ? 2'b10 : 2'b00;
  assign src2      = (w_mem_ok && r_mem_dst == ex_rt) ? 2'b01 :
                     (w_wb_ok && r_wb_dst == ex_rt)   ? 2'b10 : 2'b00;
  assign stall     = ex_memread & ex_regwrite & (ex_dst != '0) & ~flush &
                     ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
  assign bubble    = stall;
  assign stall_cnt = r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_dst <= '0;
      r_mem_rw  <= 1'b0;
      r_mem_ld  <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_rw   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_wb_dst  <= r_mem_dst;
      r_wb_rw   <= r_mem_rw;
      r_mem_dst <= (flush || stall) ? '0 : ex_dst;
      r_mem_rw  <= (flush || stall) ? 1'b0 : ex_regwrite;
      r_mem_ld  <= (flush || stall) ? 1'b0 : ex_memread;
      if (stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks of forwarding/stall against a pipeline-history model
module tb_fwd_hazard_unit;
  logic clk, rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst;
  logic id_uses_rt, ex_regwrite, ex_memread, flush;
  logic [1:0] src1, src2, s1b, s2b;
  logic stall, bubble, stb, bbb;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int n_vec = 0, n_err = 0;

  fwd_hazard_unit #(.RW(5), .CW(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .flush(flush), .src1(src1), .src2(src2),
    .stall(stall), .bubble(bubble), .stall_cnt(cnt));

  fwd_hazard_unit #(.RW(5), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .flush(flush), .src1(s1b), .src2(s2b),
    .stall(stb), .bubble(bbb), .stall_cnt(cnt2));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] dst; logic rw; logic ld; } instr_t;
  instr_t hist [1:2], nxt [1:2];
  int m_cnt, m_cnt2, n_cnt, n_cnt2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [4:0] x);
    if (hist[1].rw && !hist[1].ld && hist[1].dst != 0 && hist[1].dst == x) return 2'b01;
    if (hist[2].rw && hist[2].dst != 0 && hist[2].dst == x) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic ref_stall();
    return ex_memread && ex_regwrite && ex_dst != 0 && !flush &&
           (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
  endfunction

  task automatic model_clear();
    for (int i = 1; i <= 2; i++) hist[i] = '{dst: 5'd0, rw: 1'b0, ld: 1'b0};
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic check_now();
    logic st;
    st = ref_stall();
    chk("src1", 32'(src1), 32'(ref_sel(ex_rs)));
    chk("src2", 32'(src2), 32'(ref_sel(ex_rt)));
    chk("stall", 32'(stall), 32'(st));
    chk("bubble", 32'(bubble), 32'(st));
    chk("stall_cnt", 32'(cnt), 32'(m_cnt));
    chk("stall_cnt_cw2", 32'(cnt2), 32'(m_cnt2));
  endtask

  task automatic drive(input logic [4:0] ers, ert, edst, input logic erw, emr,
                       input logic [4:0] irs, irt, input logic iur, fl);
    logic st;
    ex_rs = ers; ex_rt = ert; ex_dst = edst; ex_regwrite = erw; ex_memread = emr;
    id_rs = irs; id_rt = irt; id_uses_rt = iur; flush = fl;
    #1;
    check_now();
    st = ref_stall();
    nxt[2] = hist[1];
    nxt[1] = (fl || st) ? '{dst: 5'd0, rw: 1'b0, ld: 1'b0} : '{dst: edst, rw: erw, ld: emr};
    n_cnt  = (st && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    n_cnt2 = (st && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
  endtask

  task automatic adv();
    @(posedge clk);
    hist = nxt; m_cnt = n_cnt; m_cnt2 = n_cnt2;
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
  endtask

  initial begin
    rst = 0;
    {id_rs, id_rt, ex_rs, ex_rt, ex_dst} = '0;
    {id_uses_rt, ex_regwrite, ex_memread, flush} = '0;
    model_clear();
    nxt = hist; n_cnt = 0; n_cnt2 = 0;
    @(negedge clk);
    ex_rs = 3; ex_rt = 3;
    #1;
    check_now();
    chk("rst_src1", 32'(src1), 0);
    rst = 1;
    @(negedge clk);
    // EX->EX then WB forward, then aged out
    drive(0, 0, 5, 1, 0, 0, 0, 0, 0); adv();
    drive(5, 0, 0, 0, 0, 0, 0, 0, 0); chk("ex_fwd_mem", 32'(src1), 1); adv();
    drive(0, 5, 0, 0, 0, 0, 0, 0, 0); chk("ex_fwd_wb", 32'(src2), 2); adv();
    drive(5, 0, 0, 0, 0, 0, 0, 0, 0); chk("ex_fwd_aged", 32'(src1), 0); adv();
    // MEM beats WB for the same register
    drive(0, 0, 4, 1, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 4, 1, 0, 0, 0, 0, 0); adv();
    drive(4, 4, 0, 0, 0, 0, 0, 0, 0); chk("prio1", 32'(src1), 1); chk("prio2", 32'(src2), 1); adv();
    // load-use: one stall cycle
    nop(); nop();
    drive(0, 0, 8, 1, 1, 8, 0, 0, 0); chk("lu_stall", 32'(stall), 1); adv();
    chk("lu_cnt", 32'(cnt), 1);
    drive(0, 0, 8, 1, 1, 0, 0, 0, 0); chk("lu_clear", 32'(stall), 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("ld_no_mem_fwd", 32'(src1), 0); adv();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0); chk("ld_wb_fwd", 32'(src1), 2); adv();
    // masks
    drive(0, 0, 8, 1, 1, 0, 8, 0, 0); chk("mask_rt", 32'(stall), 0); adv();
    drive(0, 0, 0, 1, 1, 0, 0, 1, 0); chk("mask_r0", 32'(stall), 0); adv();
    nop(); nop();
    drive(0, 0, 9, 1, 1, 9, 0, 0, 1); chk("mask_flush", 32'(stall), 0); adv();
    drive(9, 9, 0, 0, 0, 0, 0, 0, 0); chk("flush_shadow", 32'(src1), 0); adv();
    drive(9, 0, 0, 0, 0, 0, 0, 0, 0); chk("flush_shadow_wb", 32'(src1), 0); adv();
    // saturation of the narrow counter
    rst = 0; #1; model_clear(); rst = 1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 7, 1, 1, 7, 0, 0, 0); adv();
      chk("sat_cw2", 32'(cnt2), (i < 3) ? i + 1 : 3);
    end
    // random traffic with occasional async reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        rst = 0; #1; model_clear(); check_now(); rst = 1; #1;
      end
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      adv();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
